// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: classifies a debounced button into short/long presses on a
// slow sample tick and runs the IDLE/RUN/PAUSE FSM that drives the stopwatch
// counter's enable and clear.
module stopwatch_ctrl #(
    parameter int LONG_TICKS = 200,
    parameter int HOLD_W     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn,
    output logic       short_evt,
    output logic       long_evt,
    output logic       count_en,
    output logic       count_clr,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_e;

    localparam logic [HOLD_W-1:0] LONG_CNT = HOLD_W'(LONG_TICKS);

    // press classifier state
    logic              btn_q, btn_d;
    logic [HOLD_W-1:0] hcnt_q, hcnt_d;
    logic              long_done_q, long_done_d;
    logic              short_q, short_d;
    logic              long_q, long_d;

    // control FSM state
    state_e            state_q, state_d;
    logic              clr_q, clr_d;

    // Classifier next state: only tick cycles sample the button; event pulses
    // default low so they last exactly one clk.
    always_comb begin
        btn_d       = btn_q;
        hcnt_d      = hcnt_q;
        long_done_d = long_done_q;
        short_d     = 1'b0;
        long_d      = 1'b0;
        if (tick) begin
            btn_d = btn;
            if (btn && !btn_q) begin
                // press-start tick counts as hold 1
                hcnt_d      = {{(HOLD_W-1){1'b0}}, 1'b1};
                long_done_d = 1'b0;
            end else if (btn && btn_q) begin
                if (hcnt_q < LONG_CNT)
                    hcnt_d = hcnt_q + 1'b1;
                // long_done blocks auto-repeat while the count sits saturated
                if (hcnt_d == LONG_CNT && !long_done_q) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                end
            end else if (!btn && btn_q) begin
                short_d = !long_done_q;
                hcnt_d  = '0;
            end
        end
    end

    // Classifier registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q       <= 1'b0;
            hcnt_q      <= '0;
            long_done_q <= 1'b0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            btn_q       <= btn_d;
            hcnt_q      <= hcnt_d;
            long_done_q <= long_done_d;
            short_q     <= short_d;
            long_q      <= long_d;
        end
    end

    // FSM state register; the clear pulse is registered alongside so it
    // lines up with the mode change into IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    // FSM next state: a long press wins from any state, including IDLE.
    always_comb begin
        state_d = state_q;
        clr_d   = long_q;
        if (long_q) begin
            state_d = S_IDLE;
        end else if (short_q) begin
            case (state_q)
                S_IDLE:  state_d = S_RUN;
                S_RUN:   state_d = S_PAUSE;
                S_PAUSE: state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM outputs: straight decodes of registers, so no glitches.
    always_comb begin
        mode      = state_q;
        count_en  = (state_q == S_RUN);
        count_clr = clr_q;
        short_evt = short_q;
        long_evt  = long_q;
    end

endmodule
